// File: rtl/spidac_slave_mcp4921.sv
// MCP4921 DAC input-interface emulator: oversamples the SPI lines on clk,
// decodes 16-bit frames into input/output registers and exposes them on a small register bus.
module spidac_slave_mcp4921 #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  SCK,
  input  logic                  nCS,
  input  logic                  SDI,
  input  logic                  nLDAC,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [11:0]           dac_code,
  output logic                  dac_ngain,
  output logic                  dac_nshdn,
  output logic                  dac_buf,
  output logic                  update
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sckSync;
  logic [SYNC_STAGES-1:0] r_csSync;
  logic [SYNC_STAGES-1:0] r_sdiSync;
  logic [SYNC_STAGES-1:0] r_ldacSync;
  logic [15:0]            r_shiftReg;
  logic [4:0]             r_bitCnt;
  logic [14:0]            r_inputReg;
  logic                   r_pending;
  logic                   r_transp;
  logic                   r_ldacFall;
  logic [7:0]             r_frameCnt;
  logic [7:0]             r_errCnt;

  logic w_sckRise;
  logic w_csFall;
  logic w_csRise;
  logic w_ldacFall;
  logic w_ldacLow;
  logic w_sdi;
  logic w_frameOk;
  logic w_frameBad;
  logic w_latch;
  logic w_clear;
  logic w_unusedBits;

  // Sync flops reset low so a frame already in progress at reset release never shows a nCS fall.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_sckSync  <= '0;
      r_csSync   <= '0;
      r_sdiSync  <= '0;
      r_ldacSync <= '0;
    end else begin
      r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], SCK};
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], nCS};
      r_sdiSync  <= {r_sdiSync[SYNC_STAGES-2:0], SDI};
      r_ldacSync <= {r_ldacSync[SYNC_STAGES-2:0], nLDAC};
    end
  end

  assign w_sckRise  =  r_sckSync[SYNC_STAGES-2]  & ~r_sckSync[SYNC_STAGES-1];
  assign w_csFall   = ~r_csSync[SYNC_STAGES-2]   &  r_csSync[SYNC_STAGES-1];
  assign w_csRise   =  r_csSync[SYNC_STAGES-2]   & ~r_csSync[SYNC_STAGES-1];
  assign w_ldacFall = ~r_ldacSync[SYNC_STAGES-2] &  r_ldacSync[SYNC_STAGES-1];
  assign w_ldacLow  = ~r_ldacSync[SYNC_STAGES-1];
  assign w_sdi      =  r_sdiSync[SYNC_STAGES-2];

  assign w_frameOk    = (r_state == CHECK) && (r_bitCnt == 5'd16) && !r_shiftReg[15];
  assign w_frameBad   = (r_state == CHECK) && !w_frameOk;
  assign w_latch      = r_ldacFall | r_transp;
  assign w_clear      = we && (addr == DATA_WIDTH'(8'h44)) && data_in[0];
  assign w_unusedBits = ^{data_in[DATA_WIDTH-1:1], r_sdiSync[SYNC_STAGES-1]};

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state    <= IDLE;
      r_shiftReg <= '0;
      r_bitCnt   <= '0;
      r_inputReg <= '0;
      r_pending  <= 1'b0;
      r_transp   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_csFall) begin
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_sckRise) begin
            r_shiftReg <= {r_shiftReg[14:0], w_sdi};
            if (r_bitCnt != 5'd17) r_bitCnt <= r_bitCnt + 5'd1;
          end
          if (w_csRise) r_state <= CHECK;
        end
        CHECK: begin
          if (w_frameOk) r_inputReg <= r_shiftReg[14:0];
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      r_transp <= w_frameOk & w_ldacLow;
      // A new frame arriving as an older one is latched stays pending.
      if (w_frameOk)    r_pending <= 1'b1;
      else if (w_latch) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_frameCnt <= '0;
      r_errCnt   <= '0;
    end else if (w_clear) begin
      r_frameCnt <= '0;
      r_errCnt   <= '0;
    end else begin
      if (w_frameOk  && r_frameCnt != 8'hFF) r_frameCnt <= r_frameCnt + 8'd1;
      if (w_frameBad && r_errCnt   != 8'hFF) r_errCnt   <= r_errCnt + 8'd1;
    end
  end

  // The extra r_ldacFall stage aligns the nLDAC path with the transparent-latch path.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_ldacFall <= 1'b0;
      update     <= 1'b0;
      dac_code   <= '0;
      dac_ngain  <= 1'b0;
      dac_nshdn  <= 1'b0;
      dac_buf    <= 1'b0;
    end else begin
      r_ldacFall <= w_ldacFall;
      update     <= w_latch;
      if (w_latch) begin
        dac_buf   <= r_inputReg[14];
        dac_ngain <= r_inputReg[13];
        dac_nshdn <= r_inputReg[12];
        dac_code  <= r_inputReg[11:0];
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      data_out <= '0;
    end else begin
      case (addr)
        DATA_WIDTH'(8'h40): data_out <= DATA_WIDTH'(dac_code[7:0]);
        DATA_WIDTH'(8'h41): data_out <= DATA_WIDTH'({dac_buf, dac_ngain, dac_nshdn, 1'b0, dac_code[11:8]});
        DATA_WIDTH'(8'h42): data_out <= DATA_WIDTH'(r_frameCnt);
        DATA_WIDTH'(8'h43): data_out <= DATA_WIDTH'(r_errCnt);
        DATA_WIDTH'(8'h44): data_out <= DATA_WIDTH'({5'b0, (r_state == SHIFT), r_pending, 1'b0});
        default:            data_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spidac_slave_mcp4921.sv
// Bench for spidac_slave_mcp4921: random and directed SPI frames against a frame-level model,
// with a queue-based scoreboard checking every update pulse.
module tb_spidac_slave_mcp4921;

  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          res;
  logic          SCK, nCS, SDI, nLDAC, we;
  logic [DW-1:0] addr, data_in, data_out;
  logic [11:0]   dac_code;
  logic          dac_ngain, dac_nshdn, dac_buf, update;

  int checks   = 0;
  int failures = 0;
  int cycleCnt = 0;
  int lastUpdateCycle = -1;
  int csRiseCycle = 0;

  logic [14:0] expQ[$];
  logic [14:0] mInput, mOutput;
  int          mFrame, mErr;
  bit          mPending, ldacLow;

  spidac_slave_mcp4921 #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .res(res), .SCK(SCK), .nCS(nCS), .SDI(SDI), .nLDAC(nLDAC),
    .we(we), .addr(addr), .data_in(data_in), .data_out(data_out),
    .dac_code(dac_code), .dac_ngain(dac_ngain), .dac_nshdn(dac_nshdn),
    .dac_buf(dac_buf), .update(update)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Scoreboard monitor: every update pulse must match the oldest expected latch.
  always @(negedge clk) begin
    logic [14:0] exp;
    if (res && update) begin
      lastUpdateCycle = cycleCnt;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_update actual=%h required=no_update",
                 {dac_buf, dac_ngain, dac_nshdn, dac_code});
      end else begin
        exp = expQ.pop_front();
        if ({dac_buf, dac_ngain, dac_nshdn, dac_code} !== exp) begin
          failures++;
          $display("[TB] FAIL latched_value actual=%h required=%h",
                   {dac_buf, dac_ngain, dac_nshdn, dac_code}, exp);
        end
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic readReg(input logic [7:0] a, input logic [7:0] required, input string name);
    we   = 1'b0;
    addr = a;
    waitClk(1);
    checkOutput(name, 32'(data_out), 32'(required));
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
    we      = 1'b1;
    addr    = a;
    data_in = d;
    waitClk(1);
    we      = 1'b0;
  endtask

  task automatic modelLatch();
    mOutput  = mInput;
    mPending = 1'b0;
    expQ.push_back(mInput);
  endtask

  task automatic setLdac(input logic v);
    if (!v && !ldacLow) modelLatch();
    nLDAC   = v;
    ldacLow = !v;
    waitClk(8);
  endtask

  task automatic pulseLdac();
    setLdac(1'b0);
    setLdac(1'b1);
  endtask

  // Clocks nbits of value out MSB first with SCK at a quarter of clk, then updates the model.
  task automatic applyStimulus(input int nbits, input logic [16:0] value);
    nCS = 1'b0;
    waitClk(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      SDI = value[i];
      waitClk(2);
      SCK = 1'b1;
      waitClk(2);
      SCK = 1'b0;
    end
    waitClk(2);
    nCS = 1'b1;
    csRiseCycle = cycleCnt;
    if (nbits == 16 && value[15] == 1'b0) begin
      mInput   = value[14:0];
      mPending = 1'b1;
      if (mFrame < 255) mFrame++;
      if (ldacLow) modelLatch();
    end else begin
      if (mErr < 255) mErr++;
    end
    waitClk(10);
  endtask

  task automatic checkAllRegs(input string tag);
    readReg(8'h40, mOutput[7:0], {tag, "_reg40"});
    readReg(8'h41, {mOutput[14:12], 1'b0, mOutput[11:8]}, {tag, "_reg41"});
    readReg(8'h42, 8'(mFrame), {tag, "_reg42"});
    readReg(8'h43, 8'(mErr), {tag, "_reg43"});
    readReg(8'h44, {6'b0, mPending, 1'b0}, {tag, "_reg44"});
  endtask

  initial begin
    logic [16:0] v;
    int          nb, act;
    logic [11:0] sweep [3];
    sweep[0] = 12'h000; sweep[1] = 12'h555; sweep[2] = 12'hFFF;

    res = 1'b0; SCK = 1'b0; nCS = 1'b1; SDI = 1'b0; nLDAC = 1'b1;
    we = 1'b0; addr = '0; data_in = '0;
    mInput = '0; mOutput = '0; mFrame = 0; mErr = 0; mPending = 0; ldacLow = 0;

    for (int i = 0; i < 12; i++) begin
      SCK = 1'($urandom); nCS = 1'($urandom); SDI = 1'($urandom); nLDAC = 1'($urandom);
      waitClk(1);
    end
    checkOutput("reset_dac_code", 32'(dac_code), 32'h0);
    checkOutput("reset_dac_nshdn", 32'(dac_nshdn), 32'h0);
    checkOutput("reset_update", 32'(update), 32'h0);
    SCK = 1'b0; nCS = 1'b1; SDI = 1'b0; nLDAC = 1'b1;
    waitClk(2);
    res = 1'b1;
    waitClk(4);
    checkAllRegs("after_reset");

    applyStimulus(16, 17'h03ABC);
    lastUpdateCycle = -1;
    nLDAC = 1'b0; ldacLow = 1'b1; modelLatch();
    csRiseCycle = cycleCnt;
    waitClk(4);
    nLDAC = 1'b1; ldacLow = 1'b0;
    waitClk(6);
    checkOutput("ldac_latency", 32'(lastUpdateCycle - csRiseCycle), 32'(SS + 1));
    checkOutput("single_code", 32'(dac_code), 32'hABC);
    checkOutput("single_ctrl", 32'({dac_buf, dac_ngain, dac_nshdn}), 32'b011);
    readReg(8'h41, 8'h6A, "single_reg41");
    readReg(8'h42, 8'h01, "single_frame_cnt");

    setLdac(1'b0);
    lastUpdateCycle = -1;
    applyStimulus(16, 17'h01123);
    checkOutput("transparent_latency", 32'(lastUpdateCycle - csRiseCycle), 32'(SS + 2));
    checkOutput("transparent_code", 32'(dac_code), 32'h123);
    checkOutput("transparent_ctrl", 32'({dac_ngain, dac_nshdn}), 32'b01);
    setLdac(1'b1);

    applyStimulus(15, 17'h05A5A);
    applyStimulus(17, 17'h12345);
    applyStimulus(16, 17'h0B000);
    pulseLdac();
    checkOutput("error_code_kept", 32'(dac_code), 32'h123);
    checkAllRegs("errors");

    for (int i = 0; i < 40; i++) begin
      act = $urandom_range(0, 9);
      nb  = (act == 0) ? 15 : (act == 1) ? 17 : 16;
      v   = 17'($urandom);
      applyStimulus(nb, v);
      act = $urandom_range(0, 3);
      if (act == 1 && !ldacLow) pulseLdac();
      else if (act == 2) setLdac(ldacLow);
    end
    setLdac(1'b1);
    checkAllRegs("random");

    for (int i = 0; i < 300; i++) begin
      v = 17'($urandom) & 17'h07FFF;
      applyStimulus(16, v);
    end
    readReg(8'h42, 8'hFF, "frame_cnt_saturated");
    writeReg(8'h44, 8'h01);
    mFrame = 0; mErr = 0;
    readReg(8'h42, 8'h00, "frame_cnt_cleared");
    readReg(8'h43, 8'h00, "err_cnt_cleared");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(16, {5'b00011, sweep[i]});
      pulseLdac();
      checkOutput("sweep_code", 32'(dac_code), 32'(sweep[i]));
    end
    readReg(8'h43, 8'h00, "sweep_err_cnt");
    checkAllRegs("final");

    waitClk(10);
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
